// File: rtl/mbox_byte_fifo_if.sv
// Byte mailbox FIFO bundle: upstream write/status signals plus downstream valid/ready read port.
// Latency: n/a (wiring only).
// Backpressure: write side sees full/afull/empty; read side uses mbox_valid_o/mbox_ready_i.
//
// Signal suffixes are from the FIFO's point of view (_i = into the FIFO, _o = out of it).
//   slave  modport : the FIFO itself
//   master modport : whoever drives writes and consumes reads (upstream writer + WOU side)
interface mbox_byte_fifo_if #(
    parameter int WOU_DW = 8,
    parameter int AW     = 4
);
    // write side
    logic              mbox_wr_i;
    logic [WOU_DW-1:0] mbox_di_i;
    logic              mbox_full_o;
    logic              mbox_afull_o;
    logic              mbox_empty_o;
    // read side
    logic [WOU_DW-1:0] mbox_dout_o;
    logic              mbox_valid_o;
    logic              mbox_ready_i;
    // status / debug
    logic [AW:0]       mbox_level_o;
    logic              mbox_ovf_o;
    logic              mbox_ovf_clr_i;

    modport slave (
        input  mbox_wr_i,
        input  mbox_di_i,
        output mbox_full_o,
        output mbox_afull_o,
        output mbox_empty_o,
        output mbox_dout_o,
        output mbox_valid_o,
        input  mbox_ready_i,
        output mbox_level_o,
        output mbox_ovf_o,
        input  mbox_ovf_clr_i
    );

    modport master (
        output mbox_wr_i,
        output mbox_di_i,
        input  mbox_full_o,
        input  mbox_afull_o,
        input  mbox_empty_o,
        input  mbox_dout_o,
        input  mbox_valid_o,
        output mbox_ready_i,
        input  mbox_level_o,
        input  mbox_ovf_o,
        output mbox_ovf_clr_i
    );
endinterface

// File: rtl/mbox_byte_fifo.sv
// Byte-wide first-word-fall-through mailbox FIFO (DEPTH-1 entry RAM + 1 head register).
// Latency: a write into an empty FIFO is valid on mbox_dout_o one edge after the strobe.
// Backpressure: writes while full are dropped (sticky ovf); head holds stable while ready is low.
//
// Ports:
//   wb_clk_i  - single clock
//   wb_rst_i  - asynchronous, active-high reset (clears pointers, level, head, valid, ovf)
//   mbox      - slave side of mbox_byte_fifo_if:
//               write  : mbox_wr_i, mbox_di_i -> mbox_full_o, mbox_afull_o, mbox_empty_o
//               read   : mbox_dout_o, mbox_valid_o <- mbox_ready_i
//               status : mbox_level_o, mbox_ovf_o, mbox_ovf_clr_i
module mbox_byte_fifo #(
    parameter int WOU_DW   = 8,
    parameter int AW       = 4,
    parameter int AFULL_TH = 12
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    mbox_byte_fifo_if.slave       mbox
);

    localparam int DEPTH = 1 << AW;
    localparam int RAM_N = DEPTH - 1;
    localparam int LW    = AW + 1;

    localparam logic [AW-1:0] PTR_LAST  = AW'(RAM_N - 1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AFULL = LW'(AFULL_TH);

    // Reject a threshold that could never (or always) fire.
    if (AFULL_TH < 1 || AFULL_TH > DEPTH - 1) begin : g_bad_afull_th
        $error("mbox_byte_fifo: AFULL_TH out of range 1..DEPTH-1");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WOU_DW-1:0] mem_q [0:RAM_N-1];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q,  level_d;
    logic [WOU_DW-1:0] head_q,   head_d;
    logic              valid_q,  valid_d;
    logic              full_q,   full_d;
    logic              afull_q,  afull_d;
    logic              empty_q,  empty_d;
    logic              ovf_q,    ovf_d;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic wr_acc;     // write strobe that is actually stored
    logic wr_drop;    // write strobe lost because the FIFO is full
    logic pop;        // consumer takes the head byte this edge
    logic head_free;  // head register may be (re)loaded this edge
    logic ram_empty;  // nothing stored behind the head register
    logic load_ram;   // head <= RAM[rd_ptr]
    logic bypass;     // head <= mbox_di_i directly, RAM untouched
    logic ram_wr;     // write lands in RAM[wr_ptr]

    // Pointer increment with an explicit wrap: the RAM has DEPTH-1 entries,
    // so a plain power-of-two rollover would skip past the last slot.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        // full is taken from the registered level, so a write while full is
        // dropped even if a pop frees a slot on the same edge.
        wr_acc    = mbox.mbox_wr_i & ~full_q;
        wr_drop   = mbox.mbox_wr_i &  full_q;
        pop       = valid_q & mbox.mbox_ready_i;
        head_free = ~valid_q | pop;
        // level counts the head register too, so RAM occupancy is level - valid.
        ram_empty = (level_q == {{AW{1'b0}}, valid_q});
        load_ram  = head_free & ~ram_empty;
        // Bypass only when the RAM is empty, which keeps strict FIFO order.
        bypass    = head_free &  ram_empty & wr_acc;
        ram_wr    = wr_acc & ~bypass;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        head_d   = head_q;
        valid_d  = valid_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;

        if (load_ram) begin
            head_d   = mem_q[rd_ptr_q];
            valid_d  = 1'b1;
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else if (bypass) begin
            head_d   = mbox.mbox_di_i;
            valid_d  = 1'b1;
        end else if (pop) begin
            valid_d  = 1'b0;
        end

        if (ram_wr) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
    end

    always_comb begin
        level_d = level_q;
        if (wr_acc && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!wr_acc && pop) begin
            level_d = level_q - LW'(1);
        end

        // Flags come from the next level so they move on the same edge as it.
        full_d  = (level_d == LVL_FULL);
        afull_d = (level_d >= LVL_AFULL);
        empty_d = (level_d == '0);
    end

    // Set beats clear when both happen in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_drop) begin
            ovf_d = 1'b1;
        end else if (mbox.mbox_ovf_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array has no reset; the pointers alone define what is valid.
    always_ff @(posedge wb_clk_i) begin
        if (ram_wr) begin
            mem_q[wr_ptr_q] <= mbox.mbox_di_i;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mbox.mbox_full_o  = full_q;
    assign mbox.mbox_afull_o = afull_q;
    assign mbox.mbox_empty_o = empty_q;
    assign mbox.mbox_dout_o  = head_q;
    assign mbox.mbox_valid_o = valid_q;
    assign mbox.mbox_level_o = level_q;
    assign mbox.mbox_ovf_o   = ovf_q;

    // ------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------
    // The head register always fills before the RAM, so valid tracks level != 0.
    a_valid_level: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
        valid_q == (level_q != '0));

    a_level_max: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
        level_q <= LVL_FULL);

    a_flags: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
        (full_q == (level_q == LVL_FULL)) && (empty_q == (level_q == '0)) &&
        (afull_q == (level_q >= LVL_AFULL)));

endmodule

// File: tb/tb_mbox_byte_fifo.sv
// Directed bench for mbox_byte_fifo: table-driven single-cycle vectors plus
// hand-written multi-cycle sequences (fill/overflow/drain, streaming wrap,
// asynchronous reset, overflow clear priority).
module tb_mbox_byte_fifo;

    logic clk;
    logic rst;

    mbox_byte_fifo_if #(.WOU_DW(8), .AW(4)) mif ();

    mbox_byte_fifo #(.WOU_DW(8), .AW(4), .AFULL_TH(12)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .mbox     (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive at the falling edge, leave time for the rising edge,
    // return 1 time unit after it so outputs are sampled away from the edge.
    task automatic step(input logic wr, input logic [7:0] di, input logic rdy, input logic clr);
        @(negedge clk);
        mif.mbox_wr_i      = wr;
        mif.mbox_di_i      = di;
        mif.mbox_ready_i   = rdy;
        mif.mbox_ovf_clr_i = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst                = 1'b1;
        mif.mbox_wr_i      = 1'b0;
        mif.mbox_di_i      = 8'h00;
        mif.mbox_ready_i   = 1'b0;
        mif.mbox_ovf_clr_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] di;
        logic       rdy;
        logic       clr;
        logic       e_vld;
        logic [7:0] e_dout;
        logic [4:0] e_lvl;
        logic       e_full;
        logic       e_afull;
        logic       e_empty;
        logic       e_ovf;
    } vec_t;

    localparam int NV = 10;
    vec_t vt [NV];

    initial begin
        //            wr    di     rdy   clr  | vld   dout   lvl   full  afull empty ovf
        vt[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[3] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[4] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[6] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h33, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[7] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h33, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h44, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};

        rst                = 1'b1;
        mif.mbox_wr_i      = 1'b0;
        mif.mbox_di_i      = 8'h00;
        mif.mbox_ready_i   = 1'b0;
        mif.mbox_ovf_clr_i = 1'b0;

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_valid", 32'(mif.mbox_valid_o), 32'd0);
        chk("rst_empty", 32'(mif.mbox_empty_o), 32'd1);
        chk("rst_full",  32'(mif.mbox_full_o),  32'd0);
        chk("rst_afull", 32'(mif.mbox_afull_o), 32'd0);
        chk("rst_dout",  32'(mif.mbox_dout_o),  32'd0);
        chk("rst_level", 32'(mif.mbox_level_o), 32'd0);
        chk("rst_ovf",   32'(mif.mbox_ovf_o),   32'd0);

        // ---------------- single-cycle vectors ----------------
        for (int i = 0; i < NV; i++) begin
            step(vt[i].wr, vt[i].di, vt[i].rdy, vt[i].clr);
            chk($sformatf("vec%0d_valid", i), 32'(mif.mbox_valid_o), 32'(vt[i].e_vld));
            if (vt[i].e_vld)
                chk($sformatf("vec%0d_dout", i), 32'(mif.mbox_dout_o), 32'(vt[i].e_dout));
            chk($sformatf("vec%0d_level", i), 32'(mif.mbox_level_o), 32'(vt[i].e_lvl));
            chk($sformatf("vec%0d_full", i),  32'(mif.mbox_full_o),  32'(vt[i].e_full));
            chk($sformatf("vec%0d_afull", i), 32'(mif.mbox_afull_o), 32'(vt[i].e_afull));
            chk($sformatf("vec%0d_empty", i), 32'(mif.mbox_empty_o), 32'(vt[i].e_empty));
            chk($sformatf("vec%0d_ovf", i),   32'(mif.mbox_ovf_o),   32'(vt[i].e_ovf));
        end

        // ---------------- fill, overflow, clear priority, drain ----------------
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            chk($sformatf("fill%0d_level", i), 32'(mif.mbox_level_o), 32'(i + 1));
            chk($sformatf("fill%0d_afull", i), 32'(mif.mbox_afull_o), 32'((i + 1) >= 12));
            chk($sformatf("fill%0d_full", i),  32'(mif.mbox_full_o),  32'((i + 1) == 16));
            chk($sformatf("fill%0d_head", i),  32'(mif.mbox_dout_o),  32'h00);
        end
        step(1'b1, 8'h55, 1'b0, 1'b0);
        chk("ovf_set",        32'(mif.mbox_ovf_o),   32'd1);
        chk("ovf_level",      32'(mif.mbox_level_o), 32'd16);
        chk("ovf_full",       32'(mif.mbox_full_o),  32'd1);
        step(1'b1, 8'h77, 1'b0, 1'b1);
        chk("ovf_set_wins",   32'(mif.mbox_ovf_o),   32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clear",      32'(mif.mbox_ovf_o),   32'd0);
        chk("ovf_clr_level",  32'(mif.mbox_level_o), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_valid", i), 32'(mif.mbox_valid_o), 32'd1);
            chk($sformatf("drain%0d_dout", i),  32'(mif.mbox_dout_o),  32'(i));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain_valid", 32'(mif.mbox_valid_o), 32'd0);
        chk("drain_empty", 32'(mif.mbox_empty_o), 32'd1);
        chk("drain_level", 32'(mif.mbox_level_o), 32'd0);

        // ---------------- streaming across pointer wrap ----------------
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("stream_start_level", 32'(mif.mbox_level_o), 32'd5);
        for (int k = 0; k < 40; k++) begin
            chk($sformatf("stream%0d_dout", k), 32'(mif.mbox_dout_o), 32'(k));
            step(1'b1, 8'(k + 5), 1'b1, 1'b0);
            chk($sformatf("stream%0d_level", k), 32'(mif.mbox_level_o), 32'd5);
        end
        chk("stream_end_dout", 32'(mif.mbox_dout_o), 32'd40);

        // ---------------- asynchronous reset mid-drain ----------------
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("arst_pre_level", 32'(mif.mbox_level_o), 32'd7);
        @(negedge clk);
        mif.mbox_ready_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(mif.mbox_valid_o), 32'd0);
        chk("arst_level", 32'(mif.mbox_level_o), 32'd0);
        chk("arst_empty", 32'(mif.mbox_empty_o), 32'd1);
        chk("arst_full",  32'(mif.mbox_full_o),  32'd0);
        chk("arst_afull", 32'(mif.mbox_afull_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("arst_post_valid", 32'(mif.mbox_valid_o), 32'd1);
        chk("arst_post_dout",  32'(mif.mbox_dout_o),  32'h3C);
        chk("arst_post_level", 32'(mif.mbox_level_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
